// File: rtl/svm_pkg.sv
// svm_pkg: definitions shared by the SVM memory sequencer.
//   - svm_seq_state_t : sequencer state (IDLE, LOAD, SWEEP, DRAIN)
//   - SVM_NUM_SV / SVM_V_ALPHA_NUM / SVM_A_ALPHA_NUM : default bank geometry
//   - SVM_ADDR_W : default SRAM address width
//   - ceil_log2() : constant helper used to size address buses
package svm_pkg;

  function automatic int ceil_log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  localparam int SVM_NUM_SV      = 214;
  localparam int SVM_V_ALPHA_NUM = 120;
  localparam int SVM_A_ALPHA_NUM = 155;
  // The bank wrapper was sized from a 144-row macro; 8 bits still covers 214 rows.
  localparam int SVM_ADDR_W      = ceil_log2(144);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SWEEP = 2'd2,
    DRAIN = 2'd3
  } svm_seq_state_t;

endpackage

// File: rtl/svm_mem_sequencer.sv
// svm_mem_sequencer: owns address / active-low write-enable of the SVM
// support-vector + alpha SRAM bank. Data buses bypass this block.
//
//   LOAD  : streams NUM_SV rows from a valid/ready source into consecutive
//           addresses (1 row/cycle).
//   SWEEP : issues reads 0..NUM_SV-1, absorbs the 1-cycle SRAM latency and
//           presents each row downstream with valid/ready back-pressure.
//   DRAIN : waits for the last row to be accepted, then pulses done.
//
// Ports
//   clk, rst            clock, synchronous active-low reset
//   load_start          pulse, begin load phase (wins over start)
//   in_valid, in_ready  load beat handshake
//   start               pulse, begin sweep (ignored unless loaded)
//   mem_addr, mem_we    SRAM address, write enable (0 = write)
//   out_valid/out_ready row handshake toward the MAC datapath
//   out_idx, out_last   row index held in SRAM Q, last-row flag
//   v_alpha_ok          row carries a valid video alpha
//   a_alpha_ok          row carries a valid audio alpha
//   loaded, busy, done  full load seen, state != IDLE, end-of-sweep pulse
//   stall_cnt           saturating stall counter (SVM_SEQ_STALL_CNT_EN only)
//
// Build option: define SVM_SEQ_STALL_CNT_EN to add the stall_cnt port.
module svm_mem_sequencer
  import svm_pkg::*;
#(
  parameter int NUM_SV      = SVM_NUM_SV,
  parameter int V_ALPHA_NUM = SVM_V_ALPHA_NUM,
  parameter int A_ALPHA_NUM = SVM_A_ALPHA_NUM,
  parameter int ADDR_W      = SVM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              v_alpha_ok,
  output logic              a_alpha_ok,
  output logic              loaded,
  output logic              busy,
  output logic              done
`ifdef SVM_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_SV - 1);

  svm_seq_state_t    state, state_nxt;
  logic [ADDR_W-1:0] lcnt;     // next load address
  logic [ADDR_W-1:0] rd;       // next read address to issue
  logic              load_hs;  // load beat accepted
  logic              stall;    // row presented but not taken
  logic              out_hs;   // row accepted
  logic              issue;    // fresh read address on the bus this cycle
  logic              sweep_go; // accepted start

  assign load_hs  = (state == LOAD) && in_valid;
  assign stall    = out_valid && !out_ready;
  assign out_hs   = out_valid && out_ready;
  assign issue    = (state == SWEEP) && !stall;
  assign sweep_go = (state == IDLE) && start && loaded && !load_start;

  assign busy       = (state != IDLE);
  assign out_last   = (out_idx == LAST);
  assign v_alpha_ok = (int'(out_idx) < V_ALPHA_NUM);
  assign a_alpha_ok = (int'(out_idx) < A_ALPHA_NUM);

  // Next state and SRAM control
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mem_we    = 1'b1;
    mem_addr  = '0;
    case (state)
      IDLE: begin
        if (load_start)           state_nxt = LOAD;
        else if (start && loaded) state_nxt = SWEEP;
      end
      LOAD: begin
        in_ready = 1'b1;
        mem_we   = !in_valid;
        mem_addr = lcnt;
        if (in_valid && (lcnt == LAST)) state_nxt = IDLE;
      end
      SWEEP: begin
        // Under stall re-issue the row on display so SRAM Q stays put.
        mem_addr = stall ? out_idx : rd;
        if (issue && (rd == LAST)) state_nxt = DRAIN;
      end
      DRAIN: begin
        mem_addr = LAST;
        if (out_hs && out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      lcnt      <= '0;
      rd        <= '0;
      loaded    <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == DRAIN) && out_hs && out_last;

      // Load counter; saturates at the last row instead of wrapping.
      if ((state == IDLE) && load_start) begin
        loaded <= 1'b0;
        lcnt   <= '0;
      end else if (load_hs) begin
        if (lcnt == LAST) loaded <= 1'b1;
        else              lcnt   <= lcnt + ADDR_W'(1);
      end

      // Read counter; holds at the last row through DRAIN.
      if (sweep_go)                  rd <= '0;
      else if (issue && rd != LAST)  rd <= rd + ADDR_W'(1);

      // Output register tracks SRAM Q one cycle after issue.
      if (issue) begin
        out_valid <= 1'b1;
        out_idx   <= rd;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SVM_SEQ_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst)                              stall_cnt <= '0;
    else if (sweep_go)                     stall_cnt <= '0;
    else if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule
